// File: rtl/mul_sched.sv
// Issue controller wrapping a pipelined 32x32 multiplier: credit-based accept, MULHSU correction, in-order response FIFO.
// Optional build macro MUL_SCHED_BYPASS_EN forwards a completion straight to the response port when the FIFO is empty.
module mul_sched #(
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int MUL_LAT    = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [31:0]      req_s,
    input  logic [31:0]      req_t,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [TAG_W-1:0] resp_tag,
    output logic [31:0]      resp_data,
    output logic             busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;

    logic [OW-1:0]      outstanding_r;
    logic               accept_s;
    logic               pop_s;
    logic               push_s;
    logic               fifo_pop_s;
    logic               fifo_empty_s;
    logic               cpl_s;
    logic [31:0]        cpl_data_s;
    logic               is_signed_s;
    logic               hi_s;
    logic               msu_s;
    logic [31:0]        corr_s;
    logic               mul_done_s;
    logic [63:0]        mul_d_s;
    logic               unused_funct3_s;

    logic [MUL_LAT-1:0] sb_valid_r;
    logic [MUL_LAT-1:0] sb_hi_r;
    logic [TAG_W-1:0]   sb_tag_r  [MUL_LAT];
    logic [31:0]        sb_corr_r [MUL_LAT];

    logic [TAG_W-1:0]   fifo_tag_r  [FIFO_DEPTH];
    logic [31:0]        fifo_data_r [FIFO_DEPTH];
    logic [OW-1:0]      wr_ptr_r;
    logic [OW-1:0]      rd_ptr_r;

    assign unused_funct3_s = req_funct3[2];
    assign req_ready       = rstn && !flush && (outstanding_r < OW'(FIFO_DEPTH));
    assign accept_s        = req_valid && req_ready;
    assign busy            = (outstanding_r != {OW{1'b0}});

    // Decode the multiply flavour; MULHSU runs unsigned and subtracts rs2 when rs1 is negative.
    always_comb begin
        is_signed_s = 1'b0;
        hi_s        = 1'b1;
        msu_s       = 1'b0;
        case (req_funct3[1:0])
            2'b00:   hi_s = 1'b0;
            2'b01:   is_signed_s = 1'b1;
            2'b10:   msu_s = 1'b1;
            default: hi_s = 1'b1;
        endcase
        if (msu_s && req_s[31]) begin
            corr_s = req_t;
        end else begin
            corr_s = 32'h0000_0000;
        end
    end

    mul #(.LAT(MUL_LAT)) u_mul (
        .clk       (clk),
        .enable    (accept_s),
        .is_signed (is_signed_s),
        .s         (req_s),
        .t         (req_t),
        .completed (mul_done_s),
        .d         (mul_d_s)
    );

    // Sideband valid bits: the only pipeline state that must be reset or flushed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sb_valid_r <= {MUL_LAT{1'b0}};
        end else if (flush) begin
            sb_valid_r <= {MUL_LAT{1'b0}};
        end else begin
            sb_valid_r <= {sb_valid_r[MUL_LAT-2:0], accept_s};
        end
    end

    // Sideband payload travels alongside the multiplier; qualified by sb_valid_r.
    always_ff @(posedge clk) begin
        sb_hi_r      <= {sb_hi_r[MUL_LAT-2:0], hi_s};
        sb_tag_r[0]  <= req_tag;
        sb_corr_r[0] <= corr_s;
        for (int i = 1; i < MUL_LAT; i++) begin
            sb_tag_r[i]  <= sb_tag_r[i-1];
            sb_corr_r[i] <= sb_corr_r[i-1];
        end
    end

    assign cpl_s = sb_valid_r[MUL_LAT-1] && mul_done_s;

    // Select the result half and apply the MULHSU correction.
    always_comb begin
        if (sb_hi_r[MUL_LAT-1]) begin
            cpl_data_s = mul_d_s[63:32] - sb_corr_r[MUL_LAT-1];
        end else begin
            cpl_data_s = mul_d_s[31:0];
        end
    end

    // Response port: FIFO head, or the live completion when bypassing an empty FIFO.
    always_comb begin
        fifo_empty_s = (wr_ptr_r == rd_ptr_r);
        resp_valid   = !fifo_empty_s;
        resp_tag     = fifo_tag_r[rd_ptr_r[AW-1:0]];
        resp_data    = fifo_data_r[rd_ptr_r[AW-1:0]];
        push_s       = cpl_s;
`ifdef MUL_SCHED_BYPASS_EN
        if (fifo_empty_s && cpl_s) begin
            resp_valid = 1'b1;
            resp_tag   = sb_tag_r[MUL_LAT-1];
            resp_data  = cpl_data_s;
            push_s     = !resp_ready;
        end else begin
            push_s     = cpl_s;
        end
`endif
        pop_s      = resp_valid && resp_ready;
        fifo_pop_s = pop_s && !fifo_empty_s;
    end

    // FIFO pointers; credits guarantee a push never meets a full FIFO.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {OW{1'b0}};
            rd_ptr_r <= {OW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {OW{1'b0}};
            rd_ptr_r <= {OW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + OW'(1'b1);
            end
            if (fifo_pop_s) begin
                rd_ptr_r <= rd_ptr_r + OW'(1'b1);
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_tag_r[wr_ptr_r[AW-1:0]]  <= sb_tag_r[MUL_LAT-1];
            fifo_data_r[wr_ptr_r[AW-1:0]] <= cpl_data_s;
        end
    end

    // Outstanding credit counter covers both in-flight and buffered results.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outstanding_r <= {OW{1'b0}};
        end else if (flush) begin
            outstanding_r <= {OW{1'b0}};
        end else begin
            case ({accept_s, pop_s})
                2'b10:   outstanding_r <= outstanding_r + OW'(1'b1);
                2'b01:   outstanding_r <= outstanding_r - OW'(1'b1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

endmodule

// Non-stallable pipelined multiplier; internals are deliberately unreset.
module mul #(
    parameter int LAT = 4
) (
    input  logic        clk,
    input  logic        enable,
    input  logic        is_signed,
    input  logic [31:0] s,
    input  logic [31:0] t,
    output logic        completed,
    output logic [63:0] d
);

    logic [31:0]    s_r;
    logic [31:0]    t_r;
    logic           sgn_r;
    logic [LAT-1:0] vld_r;
    logic [63:0]    prod_r [LAT-1];
    logic [63:0]    a_s;
    logic [63:0]    b_s;
    logic [63:0]    prod_s;

    // Extend operands to 64 bits so a single multiply covers signed and unsigned.
    always_comb begin
        if (sgn_r) begin
            a_s = {{32{s_r[31]}}, s_r};
            b_s = {{32{t_r[31]}}, t_r};
        end else begin
            a_s = {32'h0000_0000, s_r};
            b_s = {32'h0000_0000, t_r};
        end
        prod_s = a_s * b_s;
    end

    // Operand capture, product and delay stages.
    always_ff @(posedge clk) begin
        s_r       <= s;
        t_r       <= t;
        sgn_r     <= is_signed;
        vld_r     <= {vld_r[LAT-2:0], enable};
        prod_r[0] <= prod_s;
        for (int i = 1; i < LAT - 1; i++) begin
            prod_r[i] <= prod_r[i-1];
        end
    end

    assign completed = vld_r[LAT-1];
    assign d         = prod_r[LAT-2];

endmodule
